vjtag_debug_host: RTL and testbench
===================================

// Module: vjtag_debug_host
// PURPOSE
//  Virtual-JTAG scan initiator: drives the vji_* signal set that the CPU debug-slave TAP logic consumes.
//  Turns one command (IR value plus DR word) into a full UIR->CDR->SDR->UDR->RTI sequence.
//  Shifts the DR LSB-first and returns the captured TDO word.
//  Used as the on-chip or bench-side host that replaces the sld_virtual_jtag_basic hub.
// PARAMETERS
//  DR_WIDTH  38  data-register scan length in bits
//  IR_WIDTH  2   virtual instruction register width
//  TCK_DIV   2   clk cycles per tck half-period; legal range 1..255
// PORTS
//  clk         in   1         system clock; all logic on its rising edge
//  reset       in   1         asynchronous, active-high reset
//  cmd_valid   in   1         command request
//  cmd_ready   out  1         high only in IDLE; a transfer happens when cmd_valid & cmd_ready
//  cmd_ir      in   IR_WIDTH  IR value for this scan
//  cmd_data    in   DR_WIDTH  DR word to shift out
//  rsp_valid   out  1         one-clk pulse when a scan completes
//  rsp_data    out  DR_WIDTH  captured TDO word; held until the next completion
//  busy        out  1         high whenever state != IDLE
//  vji_tck     out  1         generated scan clock
//  vji_tdi     out  1         serial data to the TAP
//  vji_tdo     in   1         serial data from the TAP
//  vji_ir_in   out  IR_WIDTH  current IR value
//  vji_uir/vji_cdr/vji_sdr/vji_udr/vji_rti  out 1  virtual-state flags; one-hot, or all low in IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, except cmd_ready=1.
//  Reset asserted mid-scan aborts the scan: no rsp_valid, and rsp_data is cleared.
//  FSM states: IDLE, UIR, CDR, SDR, UDR, RTI.
//  - IDLE -> UIR on accept. cmd_ir and cmd_data are latched. vji_ir_in takes cmd_ir at UIR entry and holds it until the next UIR.
//  - UIR, CDR, UDR and RTI each last exactly one tck period.
//  - SDR lasts exactly DR_WIDTH tck periods.
//  - RTI -> IDLE.
//  tck generation:
//  - vji_tck is low in IDLE.
//  - In the other states a half-period counter toggles vji_tck every TCK_DIV clks. Each state starts with tck low.
//  - A tck period is low half then high half. State changes happen only at falling edges, i.e. the end of a period.
//  Shift rules (SDR only):
//  - sr is loaded with cmd_data at accept.
//  - vji_tdi = sr[0] during SDR, otherwise 0.
//  - On each tck rising edge: sr <= {vji_tdo, sr[DR_WIDTH-1:1]}; bit count increments.
//  - After the DR_WIDTH-th rising edge, the next falling edge moves the FSM to UDR.
//  - Bit count width is clog2(DR_WIDTH+1) and it never wraps within a scan.
//  Completion:
//  - On the RTI->IDLE clk, rsp_valid=1 for one clk and rsp_data <= sr.
//  - cmd_ready=1 in that same clk, so back-to-back commands are accepted with no dead cycle.
//  - cmd_valid while busy is ignored and not queued.
//  Latency: an accept at clk edge t gives rsp_valid at t + 1 + 2*TCK_DIV*(DR_WIDTH+4).
//  - Defaults: 169 clks.
//  - With TCK_DIV=1 and the minimum DR_WIDTH=1: 11 clks.
// CONFIGURATION
//  VJTAG_HOST_IR_CACHE_EN
//  - Defined: a valid-bit plus last-IR register is kept. If cmd_ir equals the cached IR, the UIR state is skipped (IDLE->CDR).
//    The latency then drops by 2*TCK_DIV clks.
//  - The cache is invalidated by reset; the first command after reset always runs UIR.
//  - Undefined: UIR runs on every command.
// TESTING
//  1. Reset held, then released -> all outputs 0 except cmd_ready=1; vji_tck stays static.
//  2. Loopback (vji_tdo=vji_tdi), cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A -> rsp_data=38'h2A_5A5A_5A5A at clk t+169.
//     Exactly 38 rising tck edges occur while vji_sdr=1.
//  3. vji_tdo=1, cmd_data=38'h1 -> first SDR tdi bit is 1, remaining 37 bits are 0; rsp_data=38'h3F_FFFF_FFFF.
//  4. Back-to-back commands with cmd_valid held -> second accept happens in the rsp_valid clk of the first;
//     vji_uir is seen twice; flag one-hot checked every clk.
//  5. reset asserted after 10 SDR bits -> all vji_* outputs go to 0 immediately; no rsp_valid.
//     A following scan then completes normally.
//  6. IR_CACHE_EN defined, two commands with cmd_ir=2'b10 -> vji_uir seen only on the first;
//     second latency is t+165. Undefined -> both take 169 clks.

Source files
------------

// File: rtl/vjtag_debug_host.sv
// Virtual-JTAG scan initiator. Turns one command (IR value plus DR word)
// into a UIR -> CDR -> SDR -> UDR -> RTI sequence on the vji_* signal set.
// The DR is shifted out LSB-first, and the captured TDO word is returned.
// Optional feature macro: VJTAG_HOST_IR_CACHE_EN. When it is defined, UIR is
// skipped if the command IR matches the IR of the last UIR, provided that
// cached IR is still valid.
module vjtag_debug_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int         CNT_W    = $clog2(DR_WIDTH + 1);
    localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] BITS_ALL = CNT_W'(DR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          div_q, div_d;
    logic                tck_q, tck_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]    bit_q, bit_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifdef VJTAG_HOST_IR_CACHE_EN
    logic                cache_vld_q, cache_vld_d;
`endif

    logic                half_end;
    logic                tck_rise;
    logic                tck_fall;
    logic [DR_WIDTH-1:0] sr_shift;

    // State registers; everything is cleared by reset so an aborted scan leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tck_q       <= 1'b0;
            sr_q        <= '0;
            bit_q       <= '0;
            ir_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef VJTAG_HOST_IR_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            ir_q        <= ir_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef VJTAG_HOST_IR_CACHE_EN
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

    // Next-state logic: tck divider, scan sequencing, DR shifting and completion.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d     = state_q;
        div_d       = div_q;
        tck_d       = tck_q;
        sr_d        = sr_q;
        bit_d       = bit_q;
        ir_d        = ir_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef VJTAG_HOST_IR_CACHE_EN
        cache_vld_d = cache_vld_q;
`endif

        half_end = (div_q == DIV_LAST);
        tck_rise = (state_q != S_IDLE) && half_end && !tck_q;
        tck_fall = (state_q != S_IDLE) && half_end && tck_q;

        // A right shift plus a top-bit insert also works when DR_WIDTH is 1.
        sr_shift               = sr_q >> 1;
        sr_shift[DR_WIDTH-1]   = vji_tdo;

        // Outside IDLE, the half-period counter runs and toggles tck at each wrap.
        if (state_q != S_IDLE) begin
            div_d = half_end ? 8'd0 : div_q + 8'd1;
            if (half_end) begin
                tck_d = ~tck_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                tck_d = 1'b0;
                if (cmd_valid) begin
                    sr_d  = cmd_data;
                    bit_d = '0;
`ifdef VJTAG_HOST_IR_CACHE_EN
                    if (cache_vld_q && (cmd_ir == ir_q)) begin
                        state_d = S_CDR;
                    end else begin
                        state_d     = S_UIR;
                        ir_d        = cmd_ir;
                        cache_vld_d = 1'b1;
                    end
`else
                    state_d = S_UIR;
                    ir_d    = cmd_ir;
`endif
                end
            end
            S_UIR: begin
                if (tck_fall) state_d = S_CDR;
            end
            S_CDR: begin
                if (tck_fall) state_d = S_SDR;
            end
            S_SDR: begin
                if (tck_rise) begin
                    sr_d  = sr_shift;
                    bit_d = bit_q + 1'b1;
                end
                if (tck_fall && (bit_q == BITS_ALL)) state_d = S_UDR;
            end
            S_UDR: begin
                if (tck_fall) state_d = S_RTI;
            end
            S_RTI: begin
                if (tck_fall) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from registered state, so reset clears them immediately.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        vji_tck   = tck_q;
        vji_tdi   = (state_q == S_SDR) && sr_q[0];
        vji_ir_in = ir_q;
        vji_uir   = (state_q == S_UIR);
        vji_cdr   = (state_q == S_CDR);
        vji_sdr   = (state_q == S_SDR);
        vji_udr   = (state_q == S_UDR);
        vji_rti   = (state_q == S_RTI);
    end

endmodule

// File: tb/tb_vjtag_debug_host.sv
// Directed self-checking bench for vjtag_debug_host at default parameters.
module tb_vjtag_debug_host;

    localparam int DRW = 38;
    localparam int IRW = 2;
`ifdef VJTAG_HOST_IR_CACHE_EN
    localparam int EXP_LAT_CACHED = 165;
    localparam int EXP_UIR_TWICE  = 1;
`else
    localparam int EXP_LAT_CACHED = 169;
    localparam int EXP_UIR_TWICE  = 2;
`endif
    localparam int EXP_LAT = 169;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir;
    logic [DRW-1:0] cmd_data;
    logic           rsp_valid;
    logic [DRW-1:0] rsp_data;
    logic           busy;
    logic           vji_tck, vji_tdi, vji_tdo;
    logic [IRW-1:0] vji_ir_in;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic loop_mode = 1'b0;
    logic tdo_val   = 1'b0;
    assign vji_tdo = loop_mode ? vji_tdi : tdo_val;

    vjtag_debug_host dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .vji_tck   (vji_tck),
        .vji_tdi   (vji_tdi),
        .vji_tdo   (vji_tdo),
        .vji_ir_in (vji_ir_in),
        .vji_uir   (vji_uir),
        .vji_cdr   (vji_cdr),
        .vji_sdr   (vji_sdr),
        .vji_udr   (vji_udr),
        .vji_rti   (vji_rti)
    );

    always #5 clk = ~clk;

    // Counts rising clk edges; the edge that follows a negedge has number cyc+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor sampled on the falling clk edge, halfway between DUT updates.
    logic           tck_prev = 1'b0;
    logic           tdi_prev = 1'b0;
    logic           uir_prev = 1'b0;
    int             sdr_rises = 0;
    int             uir_count = 0;
    int             rsp_count = 0;
    logic [DRW-1:0] tdi_log = '0;
    logic           onehot_en = 1'b0;

    always @(negedge clk) begin
        if (vji_tck && !tck_prev && vji_sdr) begin
            // tdi is logged as seen in the low half, before this rise shifted sr.
            if (sdr_rises < DRW) tdi_log[sdr_rises] = tdi_prev;
            sdr_rises++;
        end
        tck_prev = vji_tck;
        tdi_prev = vji_tdi;
        if (vji_uir && !uir_prev) uir_count++;
        uir_prev = vji_uir;
        if (rsp_valid) rsp_count++;
        if (onehot_en)
            check("flags_onehot", 64'($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) <= 1), 64'd1);
    end

    task automatic clear_mon();
        @(posedge clk);
        sdr_rises = 0;
        uir_count = 0;
        tdi_log   = '0;
    endtask

    task automatic send(input logic [IRW-1:0] ir, input logic [DRW-1:0] data, output int t_acc);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(cmd_ready), 64'd1);
        t_acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int t_rsp, output logic [DRW-1:0] d);
        int n;
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", 64'(rsp_valid), 64'd1);
        t_rsp = cyc + 1;
        d     = rsp_data;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int             t_acc, t_rsp, t_acc2, t_rsp2, rc, n;
        logic [DRW-1:0] d;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ir    = '0;
        cmd_data  = '0;

        // 1: reset held then released
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_tck_static", 64'(vji_tck), 64'd0);
        end
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_outputs_zero",
              64'({rsp_valid, busy, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} | rsp_data),
              64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_tck_static", 64'(vji_tck), 64'd0);
        end
        check("idle_ready", 64'({cmd_ready, busy}), 64'b10);

        // 2: loopback scan
        loop_mode = 1'b1;
        clear_mon();
        send(2'b01, 38'h2A_5A5A_5A5A, t_acc);
        wait_rsp(t_rsp, d);
        check("loop_data", 64'(d), 64'h2A_5A5A_5A5A);
        check("loop_latency", 64'(t_rsp - t_acc), 64'(EXP_LAT));
        check("loop_sdr_rises", 64'(sdr_rises), 64'd38);
        check("loop_ir_in", 64'(vji_ir_in), 64'd1);

        // 3: constant tdo=1, single-bit DR word
        loop_mode = 1'b0;
        tdo_val   = 1'b1;
        clear_mon();
        send(2'b11, 38'h1, t_acc);
        wait_rsp(t_rsp, d);
        check("ones_data", 64'(d), 64'h3F_FFFF_FFFF);
        check("ones_tdi_bits", 64'(tdi_log), 64'h1);
        check("ones_latency", 64'(t_rsp - t_acc), 64'(EXP_LAT));

        // 4: back-to-back with cmd_valid held
        loop_mode = 1'b1;
        clear_mon();
        onehot_en = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = 2'b01;
        cmd_data  = 38'h15_1234_5678;
        check("b2b_first_ready", 64'(cmd_ready), 64'd1);
        t_acc = cyc + 1;
        @(negedge clk);
        cmd_ir   = 2'b10;
        cmd_data = 38'h0A_CAFE_F00D;
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_rsp", 64'(rsp_valid), 64'd1);
        check("b2b_ready_in_rsp_clk", 64'(cmd_ready), 64'd1);
        check("b2b_first_data", 64'(rsp_data), 64'h15_1234_5678);
        t_rsp  = cyc + 1;
        t_acc2 = t_rsp;
        check("b2b_first_latency", 64'(t_rsp - t_acc), 64'(EXP_LAT));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_accepted", 64'(busy), 64'd1);
        wait_rsp(t_rsp2, d);
        check("b2b_second_data", 64'(d), 64'h0A_CAFE_F00D);
        check("b2b_second_latency", 64'(t_rsp2 - t_acc2), 64'(EXP_LAT));
        check("b2b_uir_twice", 64'(uir_count), 64'd2);
        check("b2b_ir_in", 64'(vji_ir_in), 64'd2);
        onehot_en = 1'b0;

        // 5: reset after 10 SDR bits aborts the scan
        clear_mon();
        send(2'b01, 38'h33_0F0F_0F0F, t_acc);
        n = 0;
        while (sdr_rises < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_sdr10", 64'(sdr_rises >= 10), 64'd1);
        rc = rsp_count;
        #1 reset = 1'b1;
        #1;
        check("abort_vji_zero",
              64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        check("abort_rsp_cleared", 64'({rsp_valid, rsp_data}), 64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_count), 64'(rc));
        clear_mon();
        send(2'b10, 38'h2F_0000_FFFF, t_acc);
        wait_rsp(t_rsp, d);
        check("after_abort_data", 64'(d), 64'h2F_0000_FFFF);
        check("after_abort_latency", 64'(t_rsp - t_acc), 64'(EXP_LAT));

        // 6: two commands with the same IR after a fresh reset
        pulse_reset();
        clear_mon();
        send(2'b10, 38'h01_8000_0001, t_acc);
        wait_rsp(t_rsp, d);
        check("same_ir_first_latency", 64'(t_rsp - t_acc), 64'(EXP_LAT));
        check("same_ir_first_data", 64'(d), 64'h01_8000_0001);
        send(2'b10, 38'h3E_7777_1111, t_acc2);
        wait_rsp(t_rsp2, d);
        check("same_ir_second_latency", 64'(t_rsp2 - t_acc2), 64'(EXP_LAT_CACHED));
        check("same_ir_second_data", 64'(d), 64'h3E_7777_1111);
        check("same_ir_uir_count", 64'(uir_count), 64'(EXP_UIR_TWICE));
        check("same_ir_ir_in", 64'(vji_ir_in), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
